// File: rtl/serial_word_deser.sv
// Serial-to-parallel word assembler with a one-entry valid/ready output buffer.
// Define DESER_PARITY_BIT_EN to capture a trailing parity bit per frame and present it on P.
module serial_word_deser #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SI,
  input  logic             SV,
  output logic [WIDTH-1:0] O,
  output logic             P,
  output logic             VALID,
  input  logic             READY,
  output logic             OVERRUN
);

`ifdef DESER_PARITY_BIT_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif
  localparam int unsigned CW   = $clog2(FRAME);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

  buf_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             ovr_q, ovr_d;
  logic             complete;
  logic             load;

  always_comb begin
    complete = SV && (cnt_q == LAST);
    cnt_d    = cnt_q;
    if (SV) begin
      cnt_d = complete ? '0 : cnt_q + CW'(1);
    end
    shreg_d = shreg_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (SV && (cnt_q == CW'(i))) begin
        shreg_d[i] = SI;
      end
    end
  end

  // A completion while FULL is only accepted if the buffered word leaves on the same edge.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ovr_d   = ovr_q;
    case (state_q)
      EMPTY: begin
        if (complete) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (complete) begin
          if (READY) begin
            load = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end else if (READY) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    word_d = load ? shreg_d : word_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      shreg_q <= '0;
      word_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      word_q  <= word_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef DESER_PARITY_BIT_EN
  logic par_q, par_d;

  // The parity bit is the last bit of the frame, so it is live on SI at the completing edge.
  always_comb begin
    par_d = load ? SI : par_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign P = par_q;
`else
  assign P = 1'b0;
`endif

  assign O       = word_q;
  assign VALID   = (state_q == FULL);
  assign OVERRUN = ovr_q;

endmodule

// File: tb/tb_serial_word_deser.sv
// Directed self-checking bench for serial_word_deser (WIDTH=8); honours DESER_PARITY_BIT_EN.
module tb_serial_word_deser;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         si;
  logic         sv;
  logic [W-1:0] o;
  logic         p;
  logic         valid;
  logic         ready;
  logic         overrun;

  int n_vec;
  int n_err;

  serial_word_deser #(.WIDTH(W)) dut (
    .CLK    (clk),
    .RESET  (rst),
    .SI     (si),
    .SV     (sv),
    .O      (o),
    .P      (p),
    .VALID  (valid),
    .READY  (ready),
    .OVERRUN(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sv = 1'b1;
    si = b;
    tick();
    sv = 1'b0;
    si = 1'b0;
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int lo, input int hi, input bit gaps);
    for (int i = lo; i <= hi; i++) begin
      send_bit(w[i]);
      if (gaps) tick();
    end
  endtask

  // Last data bit plus (when built) the parity bit; rdy_last is READY at the completing edge only.
  task automatic finish_frame(input logic [W-1:0] w, input logic par, input logic rdy_last);
`ifdef DESER_PARITY_BIT_EN
    send_bit(w[W-1]);
    ready = rdy_last;
    send_bit(par);
`else
    ready = rdy_last;
    send_bit(w[W-1]);
    if (par) ; // parity bit not part of the frame in this build
`endif
    ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    si    = 1'b0;
    sv    = 1'b0;
    ready = 1'b0;
    #2;
    do_reset();
    check("rst_O", 32'(o), 32'h0);
    check("rst_P", 32'(p), 32'h0);
    check("rst_VALID", 32'(valid), 32'h0);
    check("rst_OVERRUN", 32'(overrun), 32'h0);

    // 1: LSB-first assembly and handshake
    send_bits(8'hA5, 0, W-2, 1'b0);
    check("t1_valid_early", 32'(valid), 32'h0);
    finish_frame(8'hA5, 1'b0, 1'b0);
    check("t1_valid", 32'(valid), 32'h1);
    check("t1_O", 32'(o), 32'hA5);
    check("t1_P", 32'(p), 32'h0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("t1_drain_valid", 32'(valid), 32'h0);
    check("t1_drain_O_hold", 32'(o), 32'hA5);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("t1_ready_empty", 32'(valid), 32'h0);

    // 2: gaps between every bit
    send_bits(8'hC3, 0, W-2, 1'b1);
    check("t2_valid_early", 32'(valid), 32'h0);
    finish_frame(8'hC3, 1'b0, 1'b0);
    check("t2_valid", 32'(valid), 32'h1);
    check("t2_O", 32'(o), 32'hC3);
    tick();
    tick();
    check("t2_valid_hold", 32'(valid), 32'h1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    send_bits(8'hA5, 0, W-2, 1'b1);
    check("t2b_valid_early", 32'(valid), 32'h0);
    finish_frame(8'hA5, 1'b0, 1'b0);
    check("t2b_O", 32'(o), 32'hA5);
    check("t2b_valid", 32'(valid), 32'h1);
    ready = 1'b1;
    tick();
    ready = 1'b0;

    // 3: overrun, sticky
    send_bits(8'h3C, 0, W-2, 1'b0);
    finish_frame(8'h3C, 1'b0, 1'b0);
    check("t3_O_first", 32'(o), 32'h3C);
    send_bits(8'hFF, 0, W-2, 1'b0);
    check("t3_ovr_early", 32'(overrun), 32'h0);
    finish_frame(8'hFF, 1'b1, 1'b0);
    check("t3_ovr", 32'(overrun), 32'h1);
    check("t3_O_kept", 32'(o), 32'h3C);
    check("t3_P_kept", 32'(p), 32'h0);
    check("t3_valid", 32'(valid), 32'h1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("t3_drain_valid", 32'(valid), 32'h0);
    tick();
    tick();
    check("t3_ovr_sticky", 32'(overrun), 32'h1);
    do_reset();
    check("t3_ovr_reset", 32'(overrun), 32'h0);

    // 4: drain and completion on the same edge
    send_bits(8'h3C, 0, W-2, 1'b0);
    finish_frame(8'h3C, 1'b0, 1'b0);
    send_bits(8'h81, 0, W-2, 1'b0);
    check("t4_O_pre", 32'(o), 32'h3C);
    finish_frame(8'h81, 1'b0, 1'b1);
    check("t4_valid", 32'(valid), 32'h1);
    check("t4_O", 32'(o), 32'h81);
    check("t4_ovr", 32'(overrun), 32'h0);

    // 5: reset mid-frame, with a buffered word present
    send_bits(8'hFF, 0, 4, 1'b0);
    rst = 1'b1;
    sv  = 1'b1;
    si  = 1'b1;
    tick();
    rst = 1'b0;
    sv  = 1'b0;
    si  = 1'b0;
    check("t5_O", 32'(o), 32'h0);
    check("t5_P", 32'(p), 32'h0);
    check("t5_valid", 32'(valid), 32'h0);
    check("t5_ovr", 32'(overrun), 32'h0);
    send_bits(8'h0F, 0, W-2, 1'b0);
    check("t5_valid_early", 32'(valid), 32'h0);
    finish_frame(8'h0F, 1'b0, 1'b0);
    check("t5_O_new", 32'(o), 32'h0F);
    check("t5_valid_new", 32'(valid), 32'h1);
    ready = 1'b1;
    tick();
    ready = 1'b0;

`ifdef DESER_PARITY_BIT_EN
    // 6: parity bit capture, valid only after the ninth bit
    send_bits(8'h3C, 0, W-1, 1'b0);
    check("t6_valid_8th", 32'(valid), 32'h0);
    send_bit(1'b1);
    check("t6_valid", 32'(valid), 32'h1);
    check("t6_O", 32'(o), 32'h3C);
    check("t6_P", 32'(p), 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
